// File: rtl/output_bridge.sv
// output_bridge: pairs receive requests from the core with data words popped
// from an upstream fifo. Up to two request tags are held in order; each popped
// word is written back to the core one cycle later together with the tag of the
// oldest pending request.
module output_bridge #(
  parameter int ID         = 0,
  parameter int TAG_W      = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH:0]   fifo_d,
  input  logic                  fifo_valid,
  output logic                  fifo_deq,
  input  logic                  core_req,
  input  logic [TAG_W-1:0]      core_tag,
  output logic                  core_stall,
  input  logic                  flush,
  output logic                  core_wb,
  output logic [DATA_WIDTH:0]   core_data,
  output logic [TAG_W-1:0]      core_wb_tag,
  output logic [15:0]           xfer_cnt
);

  // Elaboration-time sanity check on the parameters.
  if (TAG_W < 1 || ID < 0) begin : g_param_err
    $error("output_bridge: illegal parameter value");
  end

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [TAG_W-1:0]    head_q, head_d;   // oldest pending tag
  logic [TAG_W-1:0]    tail_q, tail_d;   // second pending tag (valid in S_TWO)
  logic                wb_q, wb_d;
  logic [DATA_WIDTH:0] data_q, data_d;
  logic [TAG_W-1:0]    wb_tag_q, wb_tag_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                accept;

  assign core_stall  = (state_q == S_TWO);
  assign fifo_deq    = (state_q != S_EMPTY) && fifo_valid && !flush;
  assign accept      = core_req && !core_stall && !flush;
  assign core_wb     = wb_q;
  assign core_data   = data_q;
  assign core_wb_tag = wb_tag_q;
  assign xfer_cnt    = cnt_q;

  // Next-state for the tag queue and the writeback registers.
  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    tail_d   = tail_q;
    wb_d     = fifo_deq;
    data_d   = data_q;
    wb_tag_d = wb_tag_q;
    cnt_d    = cnt_q;

    if (fifo_deq) begin
      data_d   = fifo_d;
      wb_tag_d = head_q;
      cnt_d    = cnt_q + 16'd1;
    end

    if (flush) begin
      state_d = S_EMPTY;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d = S_ONE;
            head_d  = core_tag;
          end
        end
        S_ONE: begin
          // Pop and push together: the new tag becomes the head directly.
          if (accept && fifo_deq) begin
            head_d = core_tag;
          end else if (accept) begin
            state_d = S_TWO;
            tail_d  = core_tag;
          end else if (fifo_deq) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (fifo_deq) begin
            state_d = S_ONE;
            head_d  = tail_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_EMPTY;
      head_q   <= '0;
      tail_q   <= '0;
      wb_q     <= 1'b0;
      data_q   <= '0;
      wb_tag_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      wb_q     <= wb_d;
      data_q   <= data_d;
      wb_tag_q <= wb_tag_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
